// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between NUM_REQ
// writeback requesters, with a registered write stage and a conflict counter.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*5-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 write_enable,
  output logic [4:0]           address3,
  output logic [31:0]          write_data,
  output logic                 pend_valid,
  output logic [4:0]           pend_addr,
  output logic [CNT_W-1:0]     conflict_cnt
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]   NR   = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr, ptr_nxt, off, gnt_idx;
  logic [PTR_W:0]     sum;
  logic [NUM_REQ-1:0] rot, gnt;
  logic               found, xfer, multi;
  logic [4:0]         sel_addr;
  logic [31:0]        sel_data;

  // Rotate valids so the highest-priority requester sits at bit 0.
  always_comb begin
    rot   = NUM_REQ'({req_valid, req_valid} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = PTR_W'(k);
      end
    end
    sum     = {1'b0, ptr} + {1'b0, off};
    gnt_idx = (sum >= NR) ? PTR_W'(sum - NR) : PTR_W'(sum);
    gnt     = NUM_REQ'(1) << gnt_idx;
    ptr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
  end

  assign req_ready = (found && !stall && !rst) ? gnt : '0;
  assign xfer      = |req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        sel_addr = req_addr[5*i +: 5];
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      write_enable <= 1'b0;
      address3     <= '0;
      write_data   <= '0;
    end else if (xfer) begin
      ptr          <= ptr_nxt;
      write_enable <= (sel_addr != 5'd0);  // x0 writes handshake but are dropped
      address3     <= sel_addr;
      write_data   <= sel_data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  assign multi = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_cnt <= '0;
    else if (!stall && multi && (conflict_cnt != '1))
      conflict_cnt <= conflict_cnt + CNT_W'(1);
  end

  assign pend_valid = write_enable;
  assign pend_addr  = address3;
endmodule
